stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
- Upstream stage of the ms/s/min/hr converter. Counts elapsed milliseconds from the system clock under a start/stop/lap/clear FSM.
- Presents a binary ms count on `count`, which the converter splits into ms/s/min/hr digits.
- Wraps at 10 h, matching the converter's hours-modulo-10 display range.

Parameters:
- CLK_PER_MS, 1000: clock cycles per millisecond (1 MHz clock by default); must be >= 2.
- BITS, 26: width of `count`; must satisfy 2^BITS >= MAX_COUNT.
- MAX_COUNT, 36000000: count modulus in ms (10 h); `count` ranges 0..MAX_COUNT-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_stop  in  1  single-cycle pulse; already debounced and edge-detected upstream.
- lap  in  1  single-cycle pulse; split-time freeze/release.
- clear  in  1  single-cycle pulse; zero the stopwatch.
- count  out  BITS  displayed ms value; feeds the converter's count input.
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP (display frozen).
- ms_tick  out  1  one-cycle pulse on every accumulator increment.
- wrapped  out  1  one-cycle pulse when the accumulator rolls MAX_COUNT-1 -> 0.

Behaviour:
- Reset (synchronous, active-high; overrides everything):
  - state=IDLE, acc=0, lap_reg=0, prescaler=0.
  - count=0, running=0, lap_active=0, ms_tick=0, wrapped=0.
- Registers:
  - acc, BITS wide: elapsed ms.
  - lap_reg, BITS wide: frozen split time.
  - prescaler: 0..CLK_PER_MS-1, width clog2(CLK_PER_MS).
- Output mux: count = lap_active ? lap_reg : acc. Driven directly from registers, no extra latency.
- Prescaler:
  - Advances only in RUN or LAP. Holds its value in PAUSE, so sub-ms phase is kept across pause.
  - Forced to 0 on entry to IDLE.
- Tick: in RUN or LAP with prescaler==CLK_PER_MS-1, on the same edge:
  - prescaler->0;
  - acc->acc+1, or 0 if acc==MAX_COUNT-1;
  - ms_tick=1 for the following cycle;
  - wrapped=1 for the following cycle on rollover only.
- FSM states: IDLE, RUN, PAUSE, LAP.
  - IDLE: start_stop -> RUN. lap and clear are ignored (clear holds zero).
  - RUN: start_stop -> PAUSE. lap -> LAP, with lap_reg<=acc (pre-increment value even if a tick coincides). clear is ignored.
  - LAP: lap -> RUN (display released to live acc). start_stop -> PAUSE, with lap_active dropped. clear is ignored. acc keeps counting throughout LAP.
  - PAUSE: start_stop -> RUN. clear -> IDLE (acc=0, prescaler=0, lap_reg=0). lap is ignored.
- Simultaneous pulses, priority clear > start_stop > lap; only the winning pulse that is legal in the current state acts:
  - PAUSE with clear+start_stop -> IDLE.
  - RUN with start_stop+lap -> PAUSE, no capture.
- A tick on the same edge as the RUN->PAUSE transition is still applied, because the state was RUN during that cycle.
- Transitions take effect on the edge where the pulse is sampled. running and lap_active are registered state decodes, valid the next cycle.
- Reset mid-operation: returns to the reset values above on the next edge; any pending tick is dropped.

Decomposition:
- Shared package, stopwatch_pkg: state enum (IDLE/RUN/PAUSE/LAP) and default constants CLK_PER_MS, MAX_COUNT, BITS. The converter stage imports the same MAX_COUNT/BITS.
- One natural sub-module, ms_prescaler: enable in, clear in, tick out, parameter CLK_PER_MS. The FSM, acc, lap_reg and output mux stay in the top.

Test Plan (CLK_PER_MS=4, MAX_COUNT=10, BITS=4):
- Reset then start_stop at cycle 0 -> running=1 next cycle; ms_tick every 4 cycles; count 1,2,3 at cycles 4,8,12 (+1 register delay).
- Let run to count=9, then next tick -> count=0 with wrapped=1 for exactly one cycle, coincident with ms_tick.
- Run to count=3, pause for 20 cycles mid-prescaler (prescaler=2), resume -> count unchanged during pause; next tick arrives 2 cycles after resume, not 4.
- At count=5 pulse lap -> count frozen at 5, lap_active=1 while acc keeps counting; lap again at acc=8 -> count=8, lap_active=0.
- PAUSE at count=6, clear+start_stop same cycle -> IDLE, count=0, running=0. clear while in RUN -> ignored, count continues.
- Assert reset while in LAP with count=4 -> next cycle all outputs 0, state IDLE; start_stop afterwards restarts from 0 with a full 4-cycle first tick.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch counter and the ms/s/min/hr converter
// stage that consumes its count.
package stopwatch_pkg;

    // Default configuration: 1 MHz system clock, 10 h wrap in ms.
    localparam int CLK_PER_MS = 1000;
    localparam int MAX_COUNT  = 36000000;
    localparam int BITS       = 26;

    // Stopwatch control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

endpackage

// File: rtl/ms_prescaler.sv
// Divides the system clock down to one tick per millisecond. The phase is
// held while disabled so a pause keeps the sub-millisecond position.
module ms_prescaler #(
    parameter int CLK_PER_MS = stopwatch_pkg::CLK_PER_MS
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_PER_MS - 1);

    logic [W-1:0] cnt;

    // Tick is combinational so the accumulator steps on the same edge the
    // prescaler wraps.
    assign tick = enable && (cnt == LAST);

    // Phase counter: wraps on tick, holds when disabled, zeroed on clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Millisecond stopwatch: start/stop/lap/clear FSM, elapsed-ms accumulator
// wrapping at MAX_COUNT, and a lap register that freezes the display.
module stopwatch_counter #(
    parameter int CLK_PER_MS = stopwatch_pkg::CLK_PER_MS,
    parameter int MAX_COUNT  = stopwatch_pkg::MAX_COUNT,
    parameter int BITS       = stopwatch_pkg::BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_stop,
    input  logic            lap,
    input  logic            clear,
    output logic [BITS-1:0] count,
    output logic            running,
    output logic            lap_active,
    output logic            ms_tick,
    output logic            wrapped
);

    import stopwatch_pkg::*;

    localparam logic [BITS-1:0] ACC_LAST = BITS'(MAX_COUNT - 1);

    state_t          state;
    state_t          state_next;
    logic            capture;   // RUN -> LAP: snapshot acc into lap_reg
    logic            zero;      // PAUSE -> IDLE: wipe acc, lap_reg, prescaler
    logic            count_en;
    logic            tick;
    logic [BITS-1:0] acc;
    logic [BITS-1:0] lap_reg;

    assign count_en = (state == RUN) || (state == LAP);

    ms_prescaler #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (count_en),
        .clear  (zero),
        .tick   (tick)
    );

    // Next-state decode; pulses illegal in the current state are ignored and
    // priority is clear > start_stop > lap among the legal ones.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can
        // leave one unassigned and infer a latch.
        state_next = state;
        capture    = 1'b0;
        zero       = 1'b0;
        case (state)
            IDLE: begin
                if (start_stop) state_next = RUN;
            end
            RUN: begin
                if (start_stop) begin
                    state_next = PAUSE;
                end else if (lap) begin
                    state_next = LAP;
                    capture    = 1'b1;
                end
            end
            LAP: begin
                if (start_stop) begin
                    state_next = PAUSE;
                end else if (lap) begin
                    state_next = RUN;
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_next = IDLE;
                    zero       = 1'b1;
                end else if (start_stop) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered status decodes of the new state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            state      <= state_next;
            running    <= (state_next == RUN) || (state_next == LAP);
            lap_active <= (state_next == LAP);
        end
    end

    // Elapsed-ms accumulator, modulo MAX_COUNT.
    always_ff @(posedge clk) begin
        if (reset || zero) begin
            acc <= '0;
        end else if (tick) begin
            acc <= (acc == ACC_LAST) ? '0 : acc + 1'b1;
        end
    end

    // Split-time snapshot; takes the pre-increment acc if a tick coincides.
    always_ff @(posedge clk) begin
        if (reset || zero) begin
            lap_reg <= '0;
        end else if (capture) begin
            lap_reg <= acc;
        end
    end

    // One-cycle event pulses following each accumulator step.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_tick <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            ms_tick <= tick;
            wrapped <= tick && (acc == ACC_LAST);
        end
    end

    // Display mux straight from registers: frozen split or live count.
    assign count = lap_active ? lap_reg : acc;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with CLK_PER_MS=4, MAX_COUNT=10,
// BITS=4. The stimulus thread queues the expected (cycle, count, wrapped) of
// every ms_tick; a monitor pops one entry per observed tick.
`timescale 1ns/1ps
module tb_stopwatch_counter;

    localparam int CPM  = 4;
    localparam int MAXC = 10;
    localparam int B    = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_stop;
    logic         lap;
    logic         clear;
    logic [B-1:0] count;
    logic         running;
    logic         lap_active;
    logic         ms_tick;
    logic         wrapped;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int cyc;
        int count;
        int wrapped;
    } exp_t;

    exp_t sb[$];

    stopwatch_counter #(
        .CLK_PER_MS (CPM),
        .MAX_COUNT  (MAXC),
        .BITS       (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .count      (count),
        .running    (running),
        .lap_active (lap_active),
        .ms_tick    (ms_tick),
        .wrapped    (wrapped)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_tick(input int c, input int v, input int w);
        exp_t x;
        x.cyc     = c;
        x.count   = v;
        x.wrapped = w;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    // Drive a one-cycle pulse; e returns the edge number that sampled it.
    task automatic pulse(input logic ss, input logic lp, input logic cl, output int e);
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        step();
        e          = cyc;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    // Monitor: each ms_tick must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t x;
        if (mon_en) begin
            if (ms_tick === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tick: ms_tick at cycle %0d, none queued", cyc);
                end else begin
                    x = sb.pop_front();
                    check("tick_cycle", 32'(cyc), 32'(x.cyc));
                    check("tick_count", 32'(count), 32'(x.count));
                    check("tick_wrapped", 32'(wrapped), 32'(x.wrapped));
                end
            end else begin
                check("wrapped_without_tick", 32'(wrapped), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int st, ps, rs, lp, cl;

        reset      = 1'b1;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        step();
        step();
        check("reset_count", 32'(count), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_lap_active", 32'(lap_active), 32'd0);
        check("reset_ms_tick", 32'(ms_tick), 32'd0);
        check("reset_wrapped", 32'(wrapped), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        step();

        // Start: tick every 4 cycles, wrap 9 -> 0 on the tenth.
        pulse(1'b1, 1'b0, 1'b0, st);
        check("start_running", 32'(running), 32'd1);
        check("start_lap_active", 32'(lap_active), 32'd0);
        check("start_count", 32'(count), 32'd0);
        for (int n = 1; n <= 9; n++) expect_tick(st + 4 * n, n, 0);
        expect_tick(st + 40, 0, 1);
        expect_tick(st + 44, 1, 0);
        expect_tick(st + 48, 2, 0);
        expect_tick(st + 52, 3, 0);
        wait_until(st + 40);
        check("wrap_count", 32'(count), 32'd0);

        // Pause with prescaler phase 2, hold 20 cycles, resume.
        wait_until(st + 53);
        pulse(1'b1, 1'b0, 1'b0, ps);
        check("pause_count", 32'(count), 32'd3);
        check("pause_running", 32'(running), 32'd0);
        wait_until(ps + 20);
        check("pause_hold_count", 32'(count), 32'd3);
        pulse(1'b1, 1'b0, 1'b0, rs);
        check("resume_running", 32'(running), 32'd1);
        expect_tick(rs + 2, 4, 0);
        expect_tick(rs + 6, 5, 0);

        // Lap at 5: display frozen while acc runs to 8, then released.
        wait_until(rs + 7);
        pulse(1'b0, 1'b1, 1'b0, lp);
        check("lap_count", 32'(count), 32'd5);
        check("lap_active_set", 32'(lap_active), 32'd1);
        check("lap_running", 32'(running), 32'd1);
        expect_tick(rs + 10, 5, 0);
        expect_tick(rs + 14, 5, 0);
        expect_tick(rs + 18, 5, 0);
        wait_until(rs + 19);
        pulse(1'b0, 1'b1, 1'b0, lp);
        check("lap_release_count", 32'(count), 32'd8);
        check("lap_active_clr", 32'(lap_active), 32'd0);
        check("lap_release_running", 32'(running), 32'd1);
        expect_tick(rs + 22, 9, 0);
        expect_tick(rs + 26, 0, 1);
        for (int k = 1; k <= 6; k++) expect_tick(rs + 26 + 4 * k, k, 0);

        // Pause at 6, then clear+start_stop together -> IDLE.
        wait_until(rs + 51);
        pulse(1'b1, 1'b0, 1'b0, ps);
        check("pause6_count", 32'(count), 32'd6);
        check("pause6_running", 32'(running), 32'd0);
        wait_until(ps + 3);
        pulse(1'b1, 1'b0, 1'b1, cl);
        check("clear_count", 32'(count), 32'd0);
        check("clear_running", 32'(running), 32'd0);
        check("clear_lap_active", 32'(lap_active), 32'd0);
        wait_until(cl + 8);
        check("idle_count", 32'(count), 32'd0);
        check("idle_running", 32'(running), 32'd0);

        // Restart: full 4-cycle first tick; clear in RUN is ignored.
        pulse(1'b1, 1'b0, 1'b0, st);
        expect_tick(st + 4, 1, 0);
        expect_tick(st + 8, 2, 0);
        expect_tick(st + 12, 3, 0);
        expect_tick(st + 16, 4, 0);
        wait_until(st + 5);
        pulse(1'b0, 1'b0, 1'b1, cl);
        check("run_clear_running", 32'(running), 32'd1);
        check("run_clear_count", 32'(count), 32'd1);

        // Lap at 4, then reset while in LAP.
        wait_until(st + 17);
        pulse(1'b0, 1'b1, 1'b0, lp);
        check("lap4_active", 32'(lap_active), 32'd1);
        check("lap4_count", 32'(count), 32'd4);
        expect_tick(st + 20, 4, 0);
        wait_until(st + 21);
        reset = 1'b1;
        step();
        check("midreset_count", 32'(count), 32'd0);
        check("midreset_running", 32'(running), 32'd0);
        check("midreset_lap_active", 32'(lap_active), 32'd0);
        check("midreset_ms_tick", 32'(ms_tick), 32'd0);
        check("midreset_wrapped", 32'(wrapped), 32'd0);
        reset = 1'b0;
        step();
        step();
        check("post_reset_count", 32'(count), 32'd0);
        check("post_reset_running", 32'(running), 32'd0);

        pulse(1'b1, 1'b0, 1'b0, st);
        check("restart_running", 32'(running), 32'd1);
        expect_tick(st + 4, 1, 0);
        expect_tick(st + 8, 2, 0);
        wait_until(st + 10);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
